// File: rtl/prod_accum_pkg.sv
// Shared types and default sizing for the product accumulator.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int PROD_W_DEF  = 8;
    localparam int ACC_W_DEF   = 12;
    localparam int N_TERMS_DEF = 4;

endpackage

// File: rtl/prod_accum_sat_add.sv
// Combinational W-bit unsigned adder; wraps by default, saturates and flags
// overflow when PROD_ACCUM_SAT_EN is defined.
module sat_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

`ifdef PROD_ACCUM_SAT_EN
    logic [W:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
    assign ovf_o = full[W];
`else
    assign sum_o = a_i + b_i;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/prod_accum.sv
// Sums groups of N_TERMS products and offers each sum on a valid/ready port.
// Optional saturating add and overflow flag: define PROD_ACCUM_SAT_EN.
//
//   state | meaning
//   IDLE  | waiting for the first product of a group; acc_out keeps last sum
//   ACCUM | group in progress, term_cnt products taken so far
//   HOLD  | finished sum presented on acc_out, input stalled
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_a,
    input  logic                           clr,
    input  logic [PROD_W-1:0]              prod_in,
    input  logic                           prod_valid,
    output logic                           prod_ready,
    output logic [ACC_W-1:0]               acc_out,
    output logic                           acc_valid,
    input  logic                           acc_ready,
    output logic [$clog2(N_TERMS+1)-1:0]   term_cnt,
    output logic                           acc_ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               xfer_in;
    logic [ACC_W-1:0]   add_a, add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_inc;

    assign prod_ready = (state_q != HOLD);
    assign acc_valid  = (state_q == HOLD);
    assign xfer_in    = prod_valid & prod_ready;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // First product of a group adds to zero, so one adder covers both cases.
    assign add_a = (state_q == ACCUM) ? acc_q : '0;

    sat_add #(
        .W (ACC_W)
    ) u_add (
        .a_i   (add_a),
        .b_i   (ACC_W'(prod_in)),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_in) begin
                        acc_d   = add_sum;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = add_ovf;
                        state_d = (N_TERMS == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer_in) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_inc == N_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // prod_ready is low here, so the next group starts a cycle later.
                    if (acc_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out  = acc_q;
    assign term_cnt = cnt_q;
    assign acc_ovf  = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: stimulus pushes expected sums, a monitor
// pops and compares on every output transfer.
module tb_prod_accum;

    typedef struct {
        logic [11:0] acc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [11:0] acc_out;
    logic        acc_valid;
    logic        acc_ready = 1'b1;
    logic [2:0]  term_cnt;
    logic        acc_ovf;

    logic [7:0]  o9_in = '0;
    logic        o9_valid = 1'b0;
    logic        o9_ready;
    logic [8:0]  o9_out;
    logic        o9_acc_valid;
    logic [2:0]  o9_cnt;
    logic        o9_ovf;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    prod_accum u_dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .clr        (clr),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .term_cnt   (term_cnt),
        .acc_ovf    (acc_ovf)
    );

    prod_accum #(.PROD_W(8), .ACC_W(9), .N_TERMS(4)) u_dut9 (
        .clk        (clk),
        .rst_a      (rst_a),
        .clr        (1'b0),
        .prod_in    (o9_in),
        .prod_valid (o9_valid),
        .prod_ready (o9_ready),
        .acc_out    (o9_out),
        .acc_valid  (o9_acc_valid),
        .acc_ready  (1'b0),
        .term_cnt   (o9_cnt),
        .acc_ovf    (o9_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic o);
        exp_t e;
        e.acc = a;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [7:0] p, output int n);
        logic r;
        logic ok;
        ok = 1'b0;
        n = 0;
        prod_in = p;
        prod_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = prod_ready;
            @(posedge clk);
            #2;
            n++;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        prod_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        int n;
        send(a, n);
        send(b, n);
        send(c, n);
        send(d, n);
    endtask

    // Monitor: a transfer out is valid & ready without a clr on the same edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_a && acc_valid && acc_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {20'd0, acc_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_acc_out", {20'd0, acc_out}, {20'd0, e.acc});
                    chk("sb_acc_ovf", {31'd0, acc_ovf}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        #12;
        chk("rst_acc_out", {20'd0, acc_out}, 32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_term_cnt", {29'd0, term_cnt}, 32'd0);
        chk("rst_acc_ovf", {31'd0, acc_ovf}, 32'd0);
        step();
        rst_a = 1'b1;
        chk("rst_prod_ready", {31'd0, prod_ready}, 32'd1);

        // Basic group 3+5+7+9
        acc_ready = 1'b1;
        push(12'd24, 1'b0);
        send4(8'd3, 8'd5, 8'd7, 8'd9);
        chk("basic_valid_latency", {31'd0, acc_valid}, 32'd1);
        chk("basic_cnt_hold", {29'd0, term_cnt}, 32'd4);
        step();
        chk("basic_idle_valid", {31'd0, acc_valid}, 32'd0);
        chk("basic_idle_ready", {31'd0, prod_ready}, 32'd1);
        chk("basic_idle_cnt", {29'd0, term_cnt}, 32'd0);
        chk("basic_idle_keeps_sum", {20'd0, acc_out}, 32'd24);

        // Backpressure 225 x4 held for 5 cycles, with a product pending
        acc_ready = 1'b0;
        push(12'd900, 1'b0);
        send4(8'd225, 8'd225, 8'd225, 8'd225);
        prod_in = 8'd10;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc_out", {20'd0, acc_out}, 32'd900);
            chk("bp_prod_ready", {31'd0, prod_ready}, 32'd0);
            chk("bp_term_cnt", {29'd0, term_cnt}, 32'd4);
            step();
        end
        acc_ready = 1'b1;

        // Gapped group 10, gap 3, 20, 30, gap 1, 40; 10 waits out the bubble
        push(12'd100, 1'b0);
        send(8'd10, n);
        chk("bubble_cycles", n, 32'd2);
        chk("gap_cnt1", {29'd0, term_cnt}, 32'd1);
        repeat (3) step();
        chk("gap_cnt_held", {29'd0, term_cnt}, 32'd1);
        send(8'd20, n);
        chk("gap_cnt2", {29'd0, term_cnt}, 32'd2);
        send(8'd30, n);
        chk("gap_cnt3", {29'd0, term_cnt}, 32'd3);
        step();
        send(8'd40, n);
        chk("gap_cnt4", {29'd0, term_cnt}, 32'd4);
        chk("gap_valid", {31'd0, acc_valid}, 32'd1);
        step();

        // Clear mid-group with a simultaneous product
        send(8'd50, n);
        send(8'd60, n);
        clr = 1'b1;
        prod_in = 8'd70;
        prod_valid = 1'b1;
        step();
        clr = 1'b0;
        prod_valid = 1'b0;
        chk("clr_cnt", {29'd0, term_cnt}, 32'd0);
        chk("clr_acc", {20'd0, acc_out}, 32'd0);
        chk("clr_valid", {31'd0, acc_valid}, 32'd0);
        chk("clr_ready", {31'd0, prod_ready}, 32'd1);
        push(12'd4, 1'b0);
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        step();

        // Clear beats a transfer out in HOLD: the sum is dropped
        acc_ready = 1'b0;
        send4(8'd2, 8'd2, 8'd2, 8'd2);
        acc_ready = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_hold_valid", {31'd0, acc_valid}, 32'd0);
        chk("clr_hold_acc", {20'd0, acc_out}, 32'd0);

        // Async reset in HOLD, no clock edge in between
        acc_ready = 1'b0;
        send4(8'd5, 8'd5, 8'd5, 8'd5);
        chk("hold_before_rst", {20'd0, acc_out}, 32'd20);
        #1 rst_a = 1'b0;
        #1;
        chk("arst_valid", {31'd0, acc_valid}, 32'd0);
        chk("arst_acc", {20'd0, acc_out}, 32'd0);
        chk("arst_cnt", {29'd0, term_cnt}, 32'd0);
        step();
        rst_a = 1'b1;
        chk("arst_release_ready", {31'd0, prod_ready}, 32'd1);
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        // Overflow with ACC_W=9
        o9_in = 8'd225;
        o9_valid = 1'b1;
        repeat (4) step();
        o9_valid = 1'b0;
        chk("ovf_valid", {31'd0, o9_acc_valid}, 32'd1);
`ifdef PROD_ACCUM_SAT_EN
        chk("ovf_acc", {23'd0, o9_out}, 32'd511);
        chk("ovf_flag", {31'd0, o9_ovf}, 32'd1);
`else
        chk("ovf_acc", {23'd0, o9_out}, 32'd388);
        chk("ovf_flag", {31'd0, o9_ovf}, 32'd0);
`endif
        step();
        chk("ovf_stays_held", {31'd0, o9_acc_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
